// File: rtl/gpio_pkg.sv
// gpio_pkg: shared register map and edge-type encodings for the GPIO PIO.
package gpio_pkg;
   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/avalon_gpio_pio_if.sv
// avalon_gpio_pio_if: Avalon-MM slave bus bundle for the GPIO PIO.
// Signals: address[2:0] word address, chipselect, write_n (active-low write),
// writedata[31:0], readdata[31:0] (zero-wait-state read data from the slave).
interface avalon_gpio_pio_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: input synchroniser, delay flop and per-bit edge detector.
// Ports: clk, reset_n (async, active-low), in_port (async pins),
// in_sync (synchronised pins), edge_pulse (one-cycle pulse per detected edge).
module gpio_sync_edge
   import gpio_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int EDGE_TYPE   = EDGE_RISE,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] in_sync,
   output logic [WIDTH-1:0] edge_pulse
);
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
   logic [WIDTH-1:0] in_prev;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         sync    <= '0;
         in_prev <= '0;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], in_port};
         in_prev <= in_sync;
      end
   assign in_sync = sync[SYNC_STAGES-1];
   assign edge_pulse = EDGE_TYPE == EDGE_RISE ? in_sync & ~in_prev :
                       EDGE_TYPE == EDGE_FALL ? ~in_sync & in_prev :
                                                in_sync ^ in_prev;
endmodule

// File: rtl/avalon_gpio_pio.sv
// avalon_gpio_pio: Avalon-MM GPIO with direction, set/clear, edge capture and IRQ.
// Ports: clk, reset_n (async, active-low), bus (Avalon-MM slave: address,
// chipselect, write_n, writedata, readdata), in_port (async pins),
// out_port (output data register), oe (direction, 1 = output), irq (level, active-high).
module avalon_gpio_pio
   import gpio_pkg::*;
#(
   parameter int               WIDTH       = 4,
   parameter logic [WIDTH-1:0] OUT_RESET   = '0,
   parameter logic [WIDTH-1:0] DIR_RESET   = '1,
   parameter int               EDGE_TYPE   = EDGE_RISE,
   parameter int               SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   avalon_gpio_pio_if.slave   bus,
   input  logic [WIDTH-1:0]   in_port,
   output logic [WIDTH-1:0]   out_port,
   output logic [WIDTH-1:0]   oe,
   output logic               irq
);
   logic [WIDTH-1:0] data_out, irq_mask, edge_cap, in_sync, edge_pulse, wd, cap_clr, rd;
   logic             wr;
   logic             unused_wd;
   gpio_sync_edge #(
      .WIDTH(WIDTH), .EDGE_TYPE(EDGE_TYPE), .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .clk(clk), .reset_n(reset_n), .in_port(in_port),
      .in_sync(in_sync), .edge_pulse(edge_pulse)
   );
   assign wr        = bus.chipselect & ~bus.write_n;
   assign wd        = bus.writedata[WIDTH-1:0];
   // writedata bits above WIDTH are deliberately dropped
   assign unused_wd = ^bus.writedata;
   assign cap_clr   = (wr && bus.address == ADDR_EDGECAP) ? wd : '0;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         data_out <= OUT_RESET;
         oe       <= DIR_RESET;
         irq_mask <= '0;
         edge_cap <= '0;
      end else begin
         if (wr && bus.address == ADDR_DATA)    data_out <= wd;
         if (wr && bus.address == ADDR_OUTSET)  data_out <= data_out | wd;
         if (wr && bus.address == ADDR_OUTCLR)  data_out <= data_out & ~wd;
         if (wr && bus.address == ADDR_DIR)     oe       <= wd;
         if (wr && bus.address == ADDR_IRQMASK) irq_mask <= wd;
         // a new edge overrides a same-cycle write-1-clear
         edge_cap <= (edge_cap & ~cap_clr) | edge_pulse;
      end
   assign rd = bus.address == ADDR_DATA    ? (oe & data_out) | (~oe & in_sync) :
               bus.address == ADDR_DIR     ? oe :
               bus.address == ADDR_IRQMASK ? irq_mask :
               bus.address == ADDR_EDGECAP ? edge_cap : '0;
   assign bus.readdata = 32'(rd);
   assign out_port     = data_out;
   assign irq          = |(edge_cap & irq_mask);
endmodule

// File: doc/avalon_gpio_pio.md
Name: avalon_gpio_pio

Overview:
Parametrised Avalon-MM GPIO peripheral, the successor to the fixed 4-bit output-only LED PIO. It adds:
- per-bit direction control;
- a synchronised input path;
- atomic set/clear of the output register;
- per-bit edge capture with a maskable level interrupt to the Nios II IRQ input.

It sits in the Qsys/Platform Designer system between the Nios data master and board pins (LEDs, keys, headers).

Parameters:
- WIDTH, 4, number of GPIO bits (1..32); register bits above WIDTH-1 ignored on write, read as 0
- OUT_RESET, 0, reset value of the output data register (WIDTH bits)
- DIR_RESET, all ones, reset value of the direction register; 1 = output, 0 = input
- EDGE_TYPE, 0, edge detected for capture: 0 rising, 1 falling, 2 any
- SYNC_STAGES, 2, input synchroniser depth (2..3)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous assert, active-low
- address  in  3  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, zero wait states, combinational from registers
- in_port  in  WIDTH  asynchronous pin inputs
- out_port  out  WIDTH  output data register
- oe  out  WIDTH  direction register, drives pin tristate enables
- irq  out  1  level interrupt, active-high

Behaviour:
- Reset is decided: reset reset_n, asynchronous, active-low; clock clk.
- Write occurs when chipselect=1 and write_n=0; it takes effect on the next clk edge.
- Reads have latency 0: readdata is valid in the same cycle address/chipselect are presented. Reads have no side effects.
- Register map:
  - 0 DATA: write loads data_out. Read returns (oe & data_out) | (~oe & in_sync).
  - 1 DIR: read/write direction register.
  - 2 IRQMASK: read/write interrupt mask.
  - 3 EDGECAP: read captured edges. Writing 1 to a bit clears it; writing 0 has no effect.
  - 4 OUTSET: write only; data_out |= writedata. Reads as 0.
  - 5 OUTCLR: write only; data_out &= ~writedata. Reads as 0.
  - 6, 7: reserved. Writes ignored, reads as 0.
- Reset values: data_out=OUT_RESET, oe=DIR_RESET, irq_mask=0, edge_cap=0, synchroniser flops=0, irq=0.
- readdata is a function of registers only, so it shows register reset values while reset_n=0.
- Input path: SYNC_STAGES-flop synchroniser produces in_sync, plus one delay flop in_prev.
  - Rising edge per bit: in_sync & ~in_prev. Falling: ~in_sync & in_prev. Any: the XOR of the two.
  - Edge detection runs on all bits regardless of oe.
- Capture latency: a pin transition is sampled on edge N. It is visible in in_sync after SYNC_STAGES edges and in edge_cap one edge later.
  - With SYNC_STAGES=2, edge_cap reads 1 three clocks after the sampling edge.
- edge_cap bit is sticky until cleared by an EDGECAP write-1.
- Simultaneous detected edge and write-1-clear on the same bit in the same cycle: set wins, bit stays 1.
- irq = |(edge_cap & irq_mask), computed combinationally from registers (no added latency).
  - Masking a pending bit drops irq immediately but does not clear edge_cap.
- A reset mid-operation clears all state immediately. Edges in flight in the synchroniser are lost. Because the synchroniser also resets to 0, no spurious rising edge is captured on release while the input is low.

Decomposition:
- Shared package (gpio_pkg): register address constants (ADDR_DATA..ADDR_OUTCLR) and EDGE_TYPE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY).
- One natural sub-module: gpio_sync_edge, WIDTH-wide. It contains the synchroniser, the delay flop and the edge-detect logic, and outputs in_sync and edge_pulse.
- The register file, address decode and irq logic stay in the top level.

Test Plan:
- Reset, WIDTH=4, OUT_RESET=4'hA, DIR_RESET=4'hF: after reset out_port=4'hA, oe=4'hF, irq=0. Read addr0 returns 32'h0000000A; read addr3 returns 0.
- Atomic set/clear: write DATA=4'h5, then OUTSET=4'h8, then OUTCLR=4'h1 (also writedata=32'hFFFF_FFF0 to OUTCLR) -> out_port sequence 5, D, C, C. Upper written bits are ignored and read back as 0.
- Mixed direction: DIR=4'b0011, data_out=4'hF, in_port=4'b1000 held for 3 clocks -> read DATA returns 4'b1011.
- Edge capture plus irq, EDGE_TYPE=0: IRQMASK=4'b0100. Drive in_port[2] 0->1 -> EDGECAP bit2=1 three clocks later, irq=1. A 1->0 transition captures nothing. Write EDGECAP=4'b0100 -> irq=0 next cycle.
- Clear/set collision: issue EDGECAP write-1 to bit1 in the same cycle edge_pulse[1]=1 -> bit1 remains 1 and irq stays asserted (mask bit1=1).
- Reset mid-operation: with edge_cap=4'hF and irq=1, pulse reset_n low for half a cycle asynchronously -> irq and edge_cap go 0 immediately; no capture after release with in_port=0.
